// File: rtl/key_event_gen.sv
// rtl/key_event_gen.sv - turns a debounced button level into press, release, long-press and auto-repeat ticks
module key_event_gen #(
    parameter int TICK_BITS    = 19,
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic db,
    output logic held,
    output logic press_tick,
    output logic release_tick,
    output logic long_tick,
    output logic repeat_tick,
    output logic step_tick
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    localparam logic [7:0] HOLD_LAST = 8'(LONG_TICKS - 1);
    localparam logic [7:0] REP_LAST  = 8'(REPEAT_TICKS - 1);

    logic [1:0]           state_q, state_d;
    logic                 db_q;
    logic [TICK_BITS-1:0] presc_q, presc_d;
    logic [7:0]           hold_cnt_q, hold_cnt_d;
    logic [7:0]           rep_cnt_q, rep_cnt_d;
    logic                 press_q, press_d;
    logic                 release_q, release_d;
    logic                 long_q, long_d;
    logic                 repeat_q, repeat_d;
    logic                 step_q, step_d;

    logic rise, fall, tick;

    assign rise = db & ~db_q;
    assign fall = ~db & db_q;
    assign tick = (presc_q == {TICK_BITS{1'b1}});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            db_q       <= 1'b0;
            presc_q    <= '0;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
            step_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            db_q       <= db;
            presc_q    <= presc_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
            step_q     <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (rise) state_d = S_HOLD;
            S_HOLD: begin
                if (fall)                             state_d = S_IDLE;
                else if (tick && hold_cnt_q == HOLD_LAST) state_d = S_REPEAT;
            end
            S_REPEAT: if (fall) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Counters stay at zero in IDLE, so a press always starts timing from a clean slate.
    always_comb begin
        presc_d    = '0;
        hold_cnt_d = '0;
        rep_cnt_d  = '0;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;
        case (state_q)
            S_IDLE: press_d = rise;
            S_HOLD: begin
                if (fall) begin
                    release_d = 1'b1;
                end else begin
                    presc_d    = presc_q + 1'b1;
                    hold_cnt_d = hold_cnt_q;
                    if (tick) begin
                        if (hold_cnt_q == HOLD_LAST) long_d = 1'b1;
                        else                         hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end
            end
            S_REPEAT: begin
                if (fall) begin
                    release_d = 1'b1;
                end else begin
                    presc_d    = presc_q + 1'b1;
                    hold_cnt_d = hold_cnt_q;
                    rep_cnt_d  = rep_cnt_q;
                    if (tick) begin
                        if (rep_cnt_q == REP_LAST) begin
                            repeat_d  = 1'b1;
                            rep_cnt_d = '0;
                        end else begin
                            rep_cnt_d = rep_cnt_q + 8'd1;
                        end
                    end
                end
            end
            default: ;
        endcase
        step_d = press_d | repeat_d;
    end

    assign held         = db_q;
    assign press_tick   = press_q;
    assign release_tick = release_q;
    assign long_tick    = long_q;
    assign repeat_tick  = repeat_q;
    assign step_tick    = step_q;

endmodule

// File: tb/tb_key_event_gen.sv
// tb/tb_key_event_gen.sv - directed bench with a press-age model of key_event_gen
module tb_key_event_gen;

    localparam int TB  = 2;
    localparam int LT  = 3;
    localparam int RT  = 2;
    localparam int T   = 1 << TB;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic db = 1'b0;
    logic held, press_tick, release_tick, long_tick, repeat_tick, step_tick;

    key_event_gen #(.TICK_BITS(TB), .LONG_TICKS(LT), .REPEAT_TICKS(RT)) dut (
        .clk(clk), .reset(reset), .db(db), .held(held),
        .press_tick(press_tick), .release_tick(release_tick),
        .long_tick(long_tick), .repeat_tick(repeat_tick), .step_tick(step_tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit started = 0;

    // Model: outputs follow from the age (cycles since press_tick) of the current press.
    bit m_prev_db = 0;
    bit m_active = 0;
    int m_age = 0;
    bit e_held, e_press, e_release, e_long, e_repeat, e_step;

    int q_press[$], q_release[$], q_long[$], q_repeat[$], q_step[$];

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    always @(posedge clk) begin
        bit r, f;
        cyc++;
        started = 1;
        if (reset) begin
            m_prev_db = 0;
            m_active  = 0;
            m_age     = 0;
            {e_held, e_press, e_release, e_long, e_repeat, e_step} = '0;
        end else begin
            r = db & ~m_prev_db;
            f = ~db & m_prev_db;
            e_press   = r;
            e_release = f & m_active;
            if (r) begin
                m_active = 1;
                m_age    = 0;
            end else if (m_active) begin
                m_age++;
                if (f) m_active = 0;
            end
            e_long   = m_active && (m_age == LT * T);
            e_repeat = m_active && (m_age > LT * T) && ((m_age - LT * T) % (RT * T) == 0);
            e_step   = e_press | e_repeat;
            e_held   = db;
            m_prev_db = db;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("held", held, e_held);
            chk("press_tick", press_tick, e_press);
            chk("release_tick", release_tick, e_release);
            chk("long_tick", long_tick, e_long);
            chk("repeat_tick", repeat_tick, e_repeat);
            chk("step_tick", step_tick, e_step);
            chk("one_hot_ticks", (32'(press_tick) + 32'(release_tick) + 32'(long_tick) + 32'(repeat_tick)) <= 1, 1);
            if (press_tick)   q_press.push_back(cyc);
            if (release_tick) q_release.push_back(cyc);
            if (long_tick)    q_long.push_back(cyc);
            if (repeat_tick)  q_repeat.push_back(cyc);
            if (step_tick)    q_step.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_press.delete(); q_release.delete(); q_long.delete();
        q_repeat.delete(); q_step.delete();
    endtask

    initial begin
        int p;
        bit seq [8];
        seq = '{1, 1, 0, 0, 0, 1, 1, 0};

        step(5);
        chk("rst_held", held, 0);
        chk("rst_ticks", {press_tick, release_tick, long_tick, repeat_tick, step_tick}, 0);
        reset = 0;
        step(2);

        clear_q();
        db = 1;
        step(41);
        p = at(q_press, 0);
        chk("A_press_cnt", q_press.size(), 1);
        chk("A_long_cnt", q_long.size(), 1);
        chk("A_long_at", at(q_long, 0) - p, 12);
        chk("A_rep_cnt", q_repeat.size(), 3);
        chk("A_rep0_at", at(q_repeat, 0) - p, 20);
        chk("A_rep1_at", at(q_repeat, 1) - p, 28);
        chk("A_rep2_at", at(q_repeat, 2) - p, 36);
        chk("A_step_cnt", q_step.size(), 4);
        chk("A_rel_none", q_release.size(), 0);
        db = 0;
        step(3);
        chk("A_rel_cnt", q_release.size(), 1);

        clear_q();
        db = 1;
        step(6);
        db = 0;
        step(4);
        chk("B_rel_at", at(q_release, 0) - at(q_press, 0), 6);
        chk("B_long_none", q_long.size(), 0);
        chk("B_held_low", held, 0);

        clear_q();
        db = 1;
        step(12);
        db = 0;
        step(4);
        chk("C_rel_at", at(q_release, 0) - at(q_press, 0), 12);
        chk("C_long_none", q_long.size(), 0);

        clear_q();
        db = 1;
        step(26);
        reset = 1;
        step(2);
        reset = 0;
        clear_q();
        step(16);
        chk("D_rel_none", q_release.size(), 0);
        chk("D_press_cnt", q_press.size(), 1);
        chk("D_long_at", at(q_long, 0) - at(q_press, 0), 12);
        db = 0;
        step(3);

        clear_q();
        for (int i = 0; i < 8; i++) begin
            db = seq[i];
            step(1);
        end
        step(3);
        chk("E_press_cnt", q_press.size(), 2);
        chk("E_rel_cnt", q_release.size(), 2);
        chk("E_step_cnt", q_step.size(), 2);
        chk("E_long_none", q_long.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
